update_center: RTL and testbench
================================

UPDATE_CENTER -- requirements
Module: update_center

Interface
REQ-001 SHALL have parameter NUM_LABEL, default 8, number of clusters.
REQ-002 SHALL have parameter WIDTH, default 16, coordinate width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024, maximum points per iteration.
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  begin a new iteration; clears accumulators.
REQ-007 SHALL have port pt_valid  in  1  point beat valid.
REQ-008 SHALL have port pt_last  in  1  marks the final point of the iteration, qualified by pt_valid.
REQ-009 SHALL have port pt_ready  out  1  high only in ACCUM.
REQ-010 SHALL have ports pointx, pointy  in  WIDTH  unsigned point coordinates.
REQ-011 SHALL have port label  in  3  assigned cluster index of the point.
REQ-012 SHALL have ports init_we  in  1, init_idx  in  3, init_x/init_y  in  WIDTH  center seeding write.
REQ-013 SHALL have ports center_x, center_y  out  NUM_LABEL*WIDTH  packed centers; label k at bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have ports busy  out  1, update_done  out  1 (one-cycle pulse), changed  out  1, overflow  out  1.

Function
REQ-015 SHALL implement FSM IDLE, ACCUM, DIV, DONE.
REQ-016 SHALL go IDLE->ACCUM on start, clearing all sums, counts and the point counter that cycle.
REQ-017 SHALL, in ACCUM, on pt_valid: sum_x[label]+=pointx, sum_y[label]+=pointy, cnt[label]+=1.
REQ-018 SHALL go ACCUM->DIV on the beat with pt_valid & pt_last; that point is accumulated.
REQ-019 SHALL use sums of WIDTH+11 bits (27) and counts of 11 bits; no wrap for up to DEPTH points.
REQ-020 SHALL drop points beyond DEPTH in an iteration and set sticky overflow until next start.
REQ-021 SHALL ignore pt_valid outside ACCUM and start outside IDLE.
REQ-022 SHALL honour init_we only in IDLE; init writes elsewhere ignored.
REQ-023 SHALL, in DIV, process labels 0..7 in order, x before y: new = sum/cnt, unsigned.
REQ-024 SHALL take exactly 28 cycles per division (1 load + 27 iterations) regardless of cnt, including cnt==0.
REQ-025 SHALL leave a center unchanged when cnt==0 (empty cluster).
REQ-026 SHALL update center_x/center_y registers only in DONE, all labels simultaneously.
REQ-027 SHALL assert update_done for one cycle in DONE, exactly 449 cycles after the pt_last beat, then return to IDLE.
REQ-028 SHALL set changed in DONE if any new center differs from its previous value, else clear it; held until next DONE.
REQ-029 SHALL drive busy high in ACCUM, DIV, DONE.

Reset
REQ-030 SHALL on rst force IDLE, all centers 0, sums/counts 0, pt_ready/busy/update_done/changed/overflow 0, regardless of state (mid-division included).

Configuration
REQ-031 SHALL, with CENTER_ROUND_EN defined, compute (sum + cnt/2)/cnt (round half up); without it, floor(sum/cnt).
REQ-032 SHALL keep latency identical in both configurations.

Structure
REQ-033 SHALL place NUM_LABEL, WIDTH, DEPTH, sum/count widths and the FSM state enum in shared package kmeans_pkg.
REQ-034 SHALL implement division in one sub-module div_seq (sequential restoring divider, 27-bit dividend, 11-bit divisor, start/done handshake).

Verification
REQ-035 Seed centers 0..7 to (0,0); start; 4 points (10,20),(12,22),(14,24),(16,26) label 3, last on 4th -> center 3 = (13,23), others (0,0), changed=1, update_done 449 cycles after last.
REQ-036 Seed center 5 = (100,200); iteration with no label-5 points -> center 5 stays (100,200).
REQ-037 Points (1,1),(2,2) label 0: floor -> (1,1); with CENTER_ROUND_EN -> (2,2).
REQ-038 1025 points of (65535,65535) label 7 -> center 7 = (65535,65535), overflow=1, 1025th point not counted.
REQ-039 rst asserted during DIV -> next cycle IDLE, all centers 0, update_done never pulses.
REQ-040 Repeat an identical iteration twice -> second update_done with changed=0; init_we during ACCUM has no effect.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared k-means constants, accumulator widths and the update FSM state type.
package kmeans_pkg;
  localparam int NUM_LABEL = 8;
  localparam int WIDTH     = 16;
  localparam int DEPTH     = 1024;
  localparam int CNT_W     = 11;
  localparam int SUM_W     = WIDTH + CNT_W;
  localparam int LBL_W     = 3;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_e;
endpackage

// File: rtl/update_center_if.sv
// Point stream into update_center: valid/ready beat with coordinates and label.
interface update_center_if #(parameter int WIDTH = kmeans_pkg::WIDTH);
  logic             pt_valid;
  logic             pt_last;
  logic             pt_ready;
  logic [WIDTH-1:0] pointx;
  logic [WIDTH-1:0] pointy;
  logic [2:0]       label;

  modport master (output pt_valid, pt_last, pointx, pointy, label, input pt_ready);
  modport slave  (input pt_valid, pt_last, pointx, pointy, label, output pt_ready);
endinterface

// File: rtl/update_center_div_seq.sv
// Sequential restoring divider: one load cycle then one quotient bit per cycle.
module div_seq
  import kmeans_pkg::*;
#(
  parameter int DVD_W = SUM_W,
  parameter int DVS_W = CNT_W,
  parameter int QUO_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [QUO_W-1:0] quotient_o,
  output logic             done_o
);
  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W:0]   rem_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   diff;

  always_comb begin
    shifted = {rem_q[DVS_W-1:0], quo_q[DVD_W-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(DVD_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        if (shifted >= {1'b0, dvs_q}) begin
          rem_q <= diff;
          quo_q <= {quo_q[DVD_W-2:0], 1'b1};
        end else begin
          rem_q <= shifted;
          quo_q <= {quo_q[DVD_W-2:0], 1'b0};
        end
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = quo_q[QUO_W-1:0];
endmodule

// File: rtl/update_center.sv
// k-means center update: accumulate labelled points, divide per label, commit centers.
// Define CENTER_ROUND_EN for round-half-up division instead of floor.
module update_center #(
  parameter int NUM_LABEL = kmeans_pkg::NUM_LABEL,
  parameter int WIDTH     = kmeans_pkg::WIDTH,
  parameter int DEPTH     = kmeans_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  update_center_if.slave             pt,
  input  logic                       init_we,
  input  logic [2:0]                 init_idx,
  input  logic [WIDTH-1:0]           init_x,
  input  logic [WIDTH-1:0]           init_y,
  output logic [NUM_LABEL*WIDTH-1:0] center_x,
  output logic [NUM_LABEL*WIDTH-1:0] center_y,
  output logic                       busy,
  output logic                       update_done,
  output logic                       changed,
  output logic                       overflow
);
  import kmeans_pkg::*;

  localparam int SW    = WIDTH + CNT_W;
  localparam int IDX_W = $clog2(2 * NUM_LABEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_LABEL - 1);

  state_e           state_q;
  logic [SW-1:0]    sum_x_q [NUM_LABEL];
  logic [SW-1:0]    sum_y_q [NUM_LABEL];
  logic [CNT_W-1:0] cnt_q   [NUM_LABEL];
  logic [WIDTH-1:0] cx_q    [NUM_LABEL];
  logic [WIDTH-1:0] cy_q    [NUM_LABEL];
  logic [WIDTH-1:0] nx_q    [NUM_LABEL];
  logic [WIDTH-1:0] ny_q    [NUM_LABEL];
  logic [CNT_W-1:0] pcnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             launch_q, ready_q, busy_q, done_q, changed_q, ovf_q;

  logic [IDX_W-1:0] op_idx;
  logic [SW-1:0]    op_sum;
  logic [CNT_W-1:0] op_cnt;
  logic [SW-1:0]    dvd;
  logic             div_start, div_done, chg;
  logic [WIDTH-1:0] div_quo;

  // Next operand is fetched while the current quotient is captured, so divisions run back to back.
  always_comb begin
    op_idx    = launch_q ? '0 : idx_q + IDX_W'(1);
    op_sum    = op_idx[0] ? sum_y_q[op_idx[IDX_W-1:1]] : sum_x_q[op_idx[IDX_W-1:1]];
    op_cnt    = cnt_q[op_idx[IDX_W-1:1]];
`ifdef CENTER_ROUND_EN
    dvd       = op_sum + SW'(op_cnt >> 1);
`else
    dvd       = op_sum;
`endif
    div_start = (state_q == DIV) && (launch_q || (div_done && idx_q != LAST_IDX));
  end

  always_comb begin
    chg = 1'b0;
    for (int unsigned k = 0; k < NUM_LABEL; k++)
      if (cnt_q[k] != '0 && (nx_q[k] != cx_q[k] || ny_q[k] != cy_q[k])) chg = 1'b1;
  end

  div_seq #(.DVD_W(SW), .DVS_W(CNT_W), .QUO_W(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (dvd),
    .divisor_i  (op_cnt),
    .quotient_o (div_quo),
    .done_o     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      idx_q     <= '0;
      launch_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int unsigned k = 0; k < NUM_LABEL; k++) begin
        sum_x_q[k] <= '0;
        sum_y_q[k] <= '0;
        cnt_q[k]   <= '0;
        cx_q[k]    <= '0;
        cy_q[k]    <= '0;
        nx_q[k]    <= '0;
        ny_q[k]    <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      launch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_we) begin
            cx_q[init_idx] <= init_x;
            cy_q[init_idx] <= init_y;
          end
          if (start) begin
            for (int unsigned k = 0; k < NUM_LABEL; k++) begin
              sum_x_q[k] <= '0;
              sum_y_q[k] <= '0;
              cnt_q[k]   <= '0;
            end
            pcnt_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (pt.pt_valid) begin
            if (pcnt_q < CNT_W'(DEPTH)) begin
              sum_x_q[pt.label] <= sum_x_q[pt.label] + SW'(pt.pointx);
              sum_y_q[pt.label] <= sum_y_q[pt.label] + SW'(pt.pointy);
              cnt_q[pt.label]   <= cnt_q[pt.label] + CNT_W'(1);
              pcnt_q            <= pcnt_q + CNT_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
            if (pt.pt_last) begin
              ready_q  <= 1'b0;
              idx_q    <= '0;
              launch_q <= 1'b1;
              state_q  <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            if (idx_q[0]) ny_q[idx_q[IDX_W-1:1]] <= div_quo;
            else          nx_q[idx_q[IDX_W-1:1]] <= div_quo;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          for (int unsigned k = 0; k < NUM_LABEL; k++) begin
            if (cnt_q[k] != '0) begin
              cx_q[k] <= nx_q[k];
              cy_q[k] <= ny_q[k];
            end
          end
          changed_q <= chg;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    center_x = '0;
    center_y = '0;
    for (int unsigned k = 0; k < NUM_LABEL; k++) begin
      center_x[k*WIDTH +: WIDTH] = cx_q[k];
      center_y[k*WIDTH +: WIDTH] = cy_q[k];
    end
  end

  assign pt.pt_ready  = ready_q;
  assign busy         = busy_q;
  assign update_done  = done_q;
  assign changed      = changed_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_update_center.sv
// Self-checking bench for update_center: reference model feeds a scoreboard of expected iteration results.
module tb_update_center;
  localparam int N = 8;
  localparam int W = 16;
  localparam int DEPTH = 1024;

  typedef struct { int x; int y; int l; } pt_t;
  typedef struct { logic [N*W-1:0] cx; logic [N*W-1:0] cy; logic chg; logic ovf; } exp_t;
  typedef struct { int lbl; int x0; int y0; int dx; int dy; int n; } vec_t;

  logic clk = 1'b0;
  logic rst, start, init_we;
  logic [2:0] init_idx;
  logic [W-1:0] init_x, init_y;
  logic [N*W-1:0] center_x, center_y;
  logic busy, update_done, changed, overflow;

  update_center_if #(.WIDTH(W)) pif ();

  update_center #(.NUM_LABEL(N), .WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .pt(pif.slave),
    .init_we(init_we), .init_idx(init_idx), .init_x(init_x), .init_y(init_y),
    .center_x(center_x), .center_y(center_y),
    .busy(busy), .update_done(update_done), .changed(changed), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcx[N], mcy[N];
  pt_t pts[$];
  exp_t sb[$];
  vec_t vt[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_c(input bit y);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(y ? mcy[k] : mcx[k]);
    return v;
  endfunction

  task automatic seed(input int idx, input int x, input int y);
    init_we = 1'b1; init_idx = 3'(idx); init_x = W'(x); init_y = W'(y);
    @(posedge clk); #1;
    init_we = 1'b0;
    mcx[idx] = x; mcy[idx] = y;
  endtask

  task automatic run_iter(input bit expect_done, input bit poke_init);
    longint sx[N], sy[N];
    int cnt[N];
    int taken, nx, ny;
    bit ovf, chg;
    exp_t e;
    taken = 0; ovf = 0; chg = 0;
    for (int k = 0; k < N; k++) begin sx[k] = 0; sy[k] = 0; cnt[k] = 0; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_accum", pif.pt_ready, 1);
    chk("busy_accum", busy, 1);
    for (int i = 0; i < pts.size(); i++) begin
      pif.pt_valid = 1'b1;
      pif.pt_last  = (i == pts.size() - 1);
      pif.pointx   = W'(pts[i].x);
      pif.pointy   = W'(pts[i].y);
      pif.label    = 3'(pts[i].l);
      if (poke_init) begin
        init_we = 1'b1; init_idx = 3'(pts[i].l); init_x = 16'd4321; init_y = 16'd1234;
      end
      @(posedge clk); #1;
      if (taken < DEPTH) begin
        sx[pts[i].l] += pts[i].x; sy[pts[i].l] += pts[i].y; cnt[pts[i].l]++; taken++;
      end else ovf = 1;
    end
    pif.pt_valid = 1'b0; pif.pt_last = 1'b0; init_we = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (cnt[k] > 0) begin
`ifdef CENTER_ROUND_EN
        nx = int'((sx[k] + cnt[k] / 2) / cnt[k]);
        ny = int'((sy[k] + cnt[k] / 2) / cnt[k]);
`else
        nx = int'(sx[k] / cnt[k]);
        ny = int'(sy[k] / cnt[k]);
`endif
        if (nx != mcx[k] || ny != mcy[k]) chg = 1;
        mcx[k] = nx; mcy[k] = ny;
      end
    end
    e.cx = pack_c(0); e.cy = pack_c(1); e.chg = chg; e.ovf = ovf;
    if (expect_done) sb.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    bit got;
    exp_t e;
    n = 0; got = 0;
    while (!got && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (update_done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("latency", n, 449);
    @(posedge clk); #1;
    chk("done_pulse", update_done, 0);
    chk("busy_idle", busy, 0);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      chk("center_x", center_x, e.cx);
      chk("center_y", center_y, e.cy);
      chk("changed", changed, e.chg);
      chk("overflow", overflow, e.ovf);
    end
  endtask

  task automatic load_cluster(input int l, input int x0, input int y0, input int dx, input int dy, input int n);
    pt_t p;
    pts.delete();
    for (int i = 0; i < n; i++) begin
      p.x = x0 + i * dx; p.y = y0 + i * dy; p.l = l;
      pts.push_back(p);
    end
  endtask

  initial begin
    int pulses;
    pt_t p;
    vt[0] = '{lbl: 0, x0: 1,     y0: 1,    dx: 1, dy: 1, n: 2};
    vt[1] = '{lbl: 6, x0: 1000,  y0: 3000, dx: 7, dy: 3, n: 5};
    vt[2] = '{lbl: 2, x0: 65535, y0: 0,    dx: 0, dy: 0, n: 3};
    vt[3] = '{lbl: 1, x0: 9,     y0: 9,    dx: 0, dy: 0, n: 1};
    vt[4] = '{lbl: 4, x0: 100,   y0: 50,   dx: 1, dy: 2, n: 6};
    for (int k = 0; k < N; k++) begin mcx[k] = 0; mcy[k] = 0; end
    rst = 1'b1; start = 1'b0; init_we = 1'b0; init_idx = '0; init_x = '0; init_y = '0;
    pif.pt_valid = 1'b0; pif.pt_last = 1'b0; pif.pointx = '0; pif.pointy = '0; pif.label = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    chk("rst_center_x", center_x, '0);
    chk("rst_center_y", center_y, '0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pif.pt_ready, 0);
    chk("rst_flags", {update_done, changed, overflow}, 0);

    // four points on label 3 -> (13,23)
    for (int k = 0; k < N; k++) seed(k, 0, 0);
    load_cluster(3, 10, 20, 2, 2, 4);
    run_iter(1, 0);
    wait_done();

    // label 5 seeded but never hit: stays put through every table iteration
    seed(5, 100, 200);
    for (int v = 0; v < 5; v++) begin
      load_cluster(vt[v].lbl, vt[v].x0, vt[v].y0, vt[v].dx, vt[v].dy, vt[v].n);
      run_iter(1, 0);
      wait_done();
    end
    chk("empty_cluster5", {center_x[5*W +: W], center_y[5*W +: W]}, {16'd100, 16'd200});

    // mixed labels, then the identical iteration again with init writes during ACCUM
    pts.delete();
    for (int i = 0; i < 20; i++) begin
      p.x = int'($urandom_range(0, 65535)); p.y = int'($urandom_range(0, 65535));
      p.l = int'($urandom_range(0, 4)) + (i % 2) * 3;
      pts.push_back(p);
    end
    run_iter(1, 0);
    wait_done();
    run_iter(1, 1);
    wait_done();
    chk("repeat_unchanged", changed, 0);

    // 1025 saturated points: last one dropped, overflow sticky
    load_cluster(7, 65535, 65535, 0, 0, 1025);
    run_iter(1, 0);
    wait_done();
    chk("overflow_set", overflow, 1);

    // next start clears overflow
    load_cluster(3, 10, 20, 2, 2, 4);
    run_iter(1, 0);
    wait_done();

    // reset in the middle of division
    load_cluster(2, 500, 600, 1, 1, 3);
    run_iter(0, 0);
    repeat (100) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < N; k++) begin mcx[k] = 0; mcy[k] = 0; end
    chk("midrst_busy", busy, 0);
    chk("midrst_center_x", center_x, '0);
    chk("midrst_center_y", center_y, '0);
    chk("midrst_flags", {pif.pt_ready, update_done, changed, overflow}, 0);
    pulses = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (update_done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);

    load_cluster(3, 10, 20, 2, 2, 4);
    run_iter(1, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
